// File: rtl/adc_share_arbiter.sv
// adc_share_arbiter: shares one soc/eoc ADC among three rfd/dav_ clients, round-robin
// Ports: clock, reset (sync, active-high); soc/eoc/x = ADC handshake and sample;
//        rfd[2:0] = client requests; dav_[2:0] = active-low data-available per client;
//        data/tag = delivered sample and owning client; err = one-cycle conversion timeout pulse
module adc_share_arbiter #(
   parameter int W       = 8,
   parameter int TIMEOUT = 64
) (
   input  logic         clock,
   input  logic         reset,
   output logic         soc,
   input  logic         eoc,
   input  logic [W-1:0] x,
   input  logic [2:0]   rfd,
   output logic [2:0]   dav_,
   output logic [W-1:0] data,
   output logic [1:0]   tag,
   output logic         err
);
   localparam int CW = $clog2(TIMEOUT);
   typedef enum logic [2:0] {IDLE, SOC, CONV, DAV, REL} state_t;
   state_t         state, state_n;
   logic [1:0]     p, p_n, p1, p2, g, tag_inc, tag_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic           soc_n, err_n;
   logic [2:0]     dav_n;
   logic [W-1:0]   data_n;
   always_comb begin
      p1      = (p == 2'd2) ? 2'd0 : p + 2'd1;
      p2      = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
      g       = rfd[p] ? p : rfd[p1] ? p1 : p2;
      tag_inc = (tag == 2'd2) ? 2'd0 : tag + 2'd1;
      state_n = state;
      p_n     = p;
      cnt_n   = cnt;
      soc_n   = soc;
      err_n   = 1'b0;
      dav_n   = dav_;
      data_n  = data;
      tag_n   = tag;
      case (state)
         IDLE: if (eoc && |rfd) begin
            tag_n   = g;
            soc_n   = 1'b1;
            cnt_n   = '0;
            state_n = SOC;
         end
         SOC: if (!eoc) begin
            soc_n   = 1'b0;
            state_n = CONV;
         end else if (cnt == CW'(TIMEOUT - 1)) begin
            soc_n   = 1'b0;
            err_n   = 1'b1;
            p_n     = tag_inc;
            state_n = IDLE;
         end else begin
            cnt_n = cnt + 1'b1;
         end
         CONV: if (eoc) begin
            data_n  = x;
            dav_n   = ~(3'b001 << tag);
            state_n = DAV;
         end
         DAV: if (!rfd[tag]) begin
            dav_n   = 3'b111;
            state_n = REL;
         end
         REL: if (rfd[tag]) begin
            p_n     = tag_inc;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         p     <= 2'd0;
         cnt   <= '0;
         soc   <= 1'b0;
         err   <= 1'b0;
         dav_  <= 3'b111;
         data  <= '0;
         tag   <= 2'd0;
      end else begin
         state <= state_n;
         p     <= p_n;
         cnt   <= cnt_n;
         soc   <= soc_n;
         err   <= err_n;
         dav_  <= dav_n;
         data  <= data_n;
         tag   <= tag_n;
      end
   end
endmodule

// File: tb/tb_adc_share_arbiter.sv
// tb_adc_share_arbiter: directed and randomized checks of adc_share_arbiter against a round-robin model
module tb_adc_share_arbiter;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       soc, err;
   logic       eoc = 1'b1;
   logic [7:0] x = 8'h00;
   logic [7:0] data;
   logic [2:0] rfd = 3'b000;
   logic [2:0] dav_;
   logic [1:0] tag;
   int checks = 0, failures = 0, cyc = 0, mp = 0;
   int lat, n, socs;
   logic [2:0] e;

   adc_share_arbiter #(.W(8), .TIMEOUT(64)) dut (
      .clock(clock), .reset(reset), .soc(soc), .eoc(eoc), .x(x),
      .rfd(rfd), .dav_(dav_), .data(data), .tag(tag), .err(err)
   );

   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic int pick(input logic [2:0] req, input int p);
      for (int k = 0; k < 3; k++)
         if (req[(p + k) % 3]) return (p + k) % 3;
      return 0;
   endfunction

   task do_txn(input logic [2:0] req, input int d1, input int d2, input logic [7:0] val, output int l);
      int g, t0;
      logic [2:0] ex;
      g  = pick(req, mp);
      t0 = cyc;
      rfd = req;
      for (int i = 0; i < 50 && soc !== 1'b1; i++) tick();
      chk("grant_soc", 32'(soc), 32'd1);
      chk("grant_tag", 32'(tag), 32'(g));
      repeat (d1 - 1) tick();
      eoc = 1'b0;
      for (int i = 0; i < 50 && soc !== 1'b0; i++) tick();
      chk("soc_fall", 32'(soc), 32'd0);
      chk("no_err", 32'(err), 32'd0);
      repeat (d2 - 1) tick();
      x   = val;
      eoc = 1'b1;
      for (int i = 0; i < 50 && dav_ === 3'b111; i++) tick();
      l  = cyc - t0;
      ex = 3'b111;
      ex[g] = 1'b0;
      chk("dav_low", 32'(dav_), 32'(ex));
      chk("data", 32'(data), 32'(val));
      chk("tag", 32'(tag), 32'(g));
      x = ~val;
      tick();
      chk("data_hold", 32'(data), 32'(val));
      chk("dav_hold", 32'(dav_), 32'(ex));
      rfd = req & ~(3'b001 << g);
      for (int i = 0; i < 10 && dav_ !== 3'b111; i++) tick();
      chk("dav_release", 32'(dav_), 32'h7);
      rfd = req;
      tick();
      mp = (g + 1) % 3;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_soc", 32'(soc), 32'd0);
      chk("rst_dav", 32'(dav_), 32'h7);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_tag", 32'(tag), 32'd0);
      reset = 1'b0;
      socs = 0;
      repeat (20) begin
         tick();
         socs += int'(soc);
      end
      chk("idle_no_soc", 32'(socs), 32'd0);

      for (int k = 0; k < 6; k++) do_txn(3'b111, 1, 1, 8'(8'h10 * (k + 1)), lat);

      do_txn(3'b010, 1, 1, 8'hA5, lat);
      chk("min_latency", 32'(lat), 32'd3);

      for (int k = 0; k < 16; k++)
         do_txn(3'b101, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 8'($urandom), lat);

      for (int k = 0; k < 12; k++)
         do_txn(3'($urandom_range(1, 7)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 8'($urandom), lat);

      rfd = 3'b001;
      for (int i = 0; i < 50 && soc !== 1'b1; i++) tick();
      chk("to_soc", 32'(soc), 32'd1);
      chk("to_tag", 32'(tag), 32'd0);
      n = 0;
      while (soc === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("to_soc_cycles", 32'(n), 32'd64);
      chk("to_err_pulse", 32'(err), 32'd1);
      chk("to_dav", 32'(dav_), 32'h7);
      rfd = 3'b000;
      tick();
      chk("to_err_clear", 32'(err), 32'd0);
      mp = 1;
      do_txn(3'b011, 2, 2, 8'h5A, lat);

      rfd = 3'b001;
      for (int i = 0; i < 50 && soc !== 1'b1; i++) tick();
      chk("rm_tag", 32'(tag), 32'd0);
      eoc = 1'b0;
      for (int i = 0; i < 50 && soc !== 1'b0; i++) tick();
      x   = 8'h77;
      eoc = 1'b1;
      for (int i = 0; i < 50 && dav_ === 3'b111; i++) tick();
      chk("rm_dav_low", 32'(dav_), 32'h6);
      reset = 1'b1;
      rfd   = 3'b110;
      tick();
      chk("rm_dav", 32'(dav_), 32'h7);
      chk("rm_soc", 32'(soc), 32'd0);
      chk("rm_data", 32'(data), 32'd0);
      reset = 1'b0;
      mp = 0;
      e = 3'b110;
      do_txn(e, 1, 3, 8'hC3, lat);
      chk("rm_next_ptr", 32'(mp), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
